// File: rtl/vbs_pkg.sv
// vbs_pkg: shared types and default timing for the VBS capture path.
//   state_t      capture FSM states
//   *_DEF        default timing constants (clk / lines / pixels)
//   ADDR_W       video RAM byte address width
//   maj3         3-input majority helper for the optional glitch filter
package vbs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        VBLANK,
        LINE_WAIT,
        ACTIVE,
        DONE
    } state_t;

    localparam int unsigned HSYNC_MAX_DEF  = 40;
    localparam int unsigned VSYNC_MIN_DEF  = 200;
    localparam int unsigned Y_START_DEF    = 35;
    localparam int unsigned X_START_DEF    = 94;
    localparam int unsigned X_PIXELS_DEF   = 320;
    localparam int unsigned Y_LINES_DEF    = 192;

    localparam int unsigned ADDR_W         = 13;
    localparam int unsigned BYTES_PER_LINE = X_PIXELS_DEF / 8;
    localparam int unsigned LOW_W          = 9;
    localparam int unsigned HCNT_W         = 10;
    localparam int unsigned PX_W           = 9;
    localparam int unsigned CNT_W          = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/vbs_sync_separator.sv
// vbs_sync_separator: synchronises sync/pixel, classifies sync pulses and
// tracks horizontal position relative to the line-sync falling edge.
// Build option: VBS_CAPTURE_GLITCH_FILTER_EN adds a 3-tap majority filter
// after each synchroniser (latency 4 clk instead of 2, equal on both inputs).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sync, pixel  raw asynchronous video inputs (sync active low)
//   pixel_s      synchronised (optionally filtered) pixel
//   hs_evt       1-clk pulse: line sync pulse ended (low <= HSYNC_MAX clk)
//   vs_evt       1-clk pulse: sync low for VSYNC_MIN clk
//   h_cnt        clk since falling edge of the last line sync (saturating)
module vbs_sync_separator
    import vbs_pkg::*;
#(
    parameter int unsigned HSYNC_MAX = HSYNC_MAX_DEF,
    parameter int unsigned VSYNC_MIN = VSYNC_MIN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              pixel,
    output logic              pixel_s,
    output logic              hs_evt,
    output logic              vs_evt,
    output logic [HCNT_W-1:0] h_cnt
);

    logic [1:0]       sync_ff;
    logic [1:0]       pix_ff;
    logic             sync_v;
    logic             sync_d;
    logic [LOW_W-1:0] low_cnt;
    logic             hs_c;
    logic             vs_c;

    // Two-flop synchronisers; sync idles high so it resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 2'b11;
            pix_ff  <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], sync};
            pix_ff  <= {pix_ff[0], pixel};
        end
    end

`ifdef VBS_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] sync_dl;
    logic [1:0] pix_dl;
    logic       sync_f;
    logic       pix_f;

    // Majority over three consecutive samples drops single-clk glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dl <= 2'b11;
            pix_dl  <= 2'b00;
            sync_f  <= 1'b1;
            pix_f   <= 1'b0;
        end else begin
            sync_dl <= {sync_dl[0], sync_ff[1]};
            pix_dl  <= {pix_dl[0], pix_ff[1]};
            sync_f  <= maj3(sync_ff[1], sync_dl[0], sync_dl[1]);
            pix_f   <= maj3(pix_ff[1], pix_dl[0], pix_dl[1]);
        end
    end

    assign sync_v  = sync_f;
    assign pixel_s = pix_f;
`else
    assign sync_v  = sync_ff[1];
    assign pixel_s = pix_ff[1];
`endif

    // Rising edge ends a pulse; low_cnt then holds its full length.
    assign hs_c = sync_v && !sync_d && (low_cnt <= LOW_W'(HSYNC_MAX));
    // Fires once, on the clk the low run reaches VSYNC_MIN.
    assign vs_c = !sync_v && (low_cnt == LOW_W'(VSYNC_MIN - 1));

    // Low-run counter, event registers and edge-relative horizontal counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d  <= 1'b1;
            low_cnt <= '0;
            hs_evt  <= 1'b0;
            vs_evt  <= 1'b0;
            h_cnt   <= '0;
        end else begin
            sync_d <= sync_v;
            if (!sync_v) begin
                if (low_cnt != '1) begin
                    low_cnt <= low_cnt + LOW_W'(1);
                end
            end else begin
                low_cnt <= '0;
            end
            hs_evt <= hs_c;
            vs_evt <= vs_c;
            // Re-reference to the falling edge: pulse length plus this clk.
            if (hs_c) begin
                h_cnt <= HCNT_W'(low_cnt) + HCNT_W'(1);
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + HCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vbs_capture.sv
// vbs_capture: VBS link receiver / frame grabber. Writes X_PIXELS x Y_LINES
// mono frames, 8 px per byte MSB = leftmost, into a byte-addressed RAM port.
// Build option: VBS_CAPTURE_GLITCH_FILTER_EN (see vbs_sync_separator).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   enable        arm capture (sampled in IDLE and at frame end)
//   sync, pixel   raw video inputs, sync active low, pixel 1 = white
//   wr_en         one-clk RAM write strobe
//   wr_addr       byte address
//   wr_data       packed pixels, bit 7 = leftmost
//   frame_done    one-clk pulse after the last byte of a frame
//   busy          state is not IDLE
//   err           sticky: field sync arrived mid-frame
module vbs_capture
    import vbs_pkg::*;
#(
    parameter int unsigned HSYNC_MAX = HSYNC_MAX_DEF,
    parameter int unsigned VSYNC_MIN = VSYNC_MIN_DEF,
    parameter int unsigned Y_START   = Y_START_DEF,
    parameter int unsigned X_START   = X_START_DEF,
    parameter int unsigned X_PIXELS  = X_PIXELS_DEF,
    parameter int unsigned Y_LINES   = Y_LINES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sync,
    input  logic              pixel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err
);

    state_t            state;
    state_t            state_nx;
    logic              pixel_s;
    logic              hs_evt;
    logic              vs_evt;
    logic [HCNT_W-1:0] h_cnt;
    logic              armed;
    logic [CNT_W-1:0]  line_cnt;
    logic [CNT_W-1:0]  y_cnt;
    logic [PX_W-1:0]   px_cnt;
    logic [7:0]        shreg;
    logic [ADDR_W-1:0] addr;
    logic              last_px;
    logic              last_line;
    logic              line_go;
    logic              sample_c;
    logic              write_c;
    logic              new_field_c;
    logic              abort_c;
    logic              vb_line_c;
    logic              line_end_c;

    vbs_sync_separator #(
        .HSYNC_MAX (HSYNC_MAX),
        .VSYNC_MIN (VSYNC_MIN)
    ) u_sep (
        .clk     (clk),
        .rst_n   (reset_n),
        .sync    (sync),
        .pixel   (pixel),
        .pixel_s (pixel_s),
        .hs_evt  (hs_evt),
        .vs_evt  (vs_evt),
        .h_cnt   (h_cnt)
    );

    assign last_px   = (px_cnt == PX_W'(X_PIXELS - 1));
    assign last_line = (y_cnt == CNT_W'(Y_LINES - 1));
    // armed ensures the line start is counted from an hs seen after ACTIVE.
    assign line_go   = armed && (h_cnt == HCNT_W'(X_START - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (enable) state_nx = WAIT_VS;
            WAIT_VS:   if (vs_evt) state_nx = VBLANK;
            VBLANK: begin
                if (vs_evt) begin
                    state_nx = VBLANK;
                end else if (hs_evt && (line_cnt == CNT_W'(Y_START - 1))) begin
                    state_nx = LINE_WAIT;
                end
            end
            LINE_WAIT: begin
                if (vs_evt) begin
                    state_nx = VBLANK;
                end else if (line_go) begin
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_evt) begin
                    state_nx = VBLANK;
                end else if (last_px) begin
                    state_nx = last_line ? DONE : LINE_WAIT;
                end
            end
            DONE:      state_nx = enable ? WAIT_VS : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Control strobes; a field sync pre-empts any pixel work on that clk.
    always_comb begin
        sample_c    = 1'b0;
        write_c     = 1'b0;
        new_field_c = 1'b0;
        abort_c     = 1'b0;
        vb_line_c   = 1'b0;
        line_end_c  = 1'b0;
        if (vs_evt) begin
            new_field_c = (state != IDLE) && (state != DONE);
            abort_c     = (state == LINE_WAIT) || (state == ACTIVE);
        end else begin
            sample_c   = (state == ACTIVE);
            write_c    = sample_c && (px_cnt[2:0] == 3'b111);
            line_end_c = sample_c && last_px;
            vb_line_c  = (state == VBLANK) && hs_evt;
        end
    end

    // Counters, pixel packer and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed      <= 1'b0;
            line_cnt   <= '0;
            y_cnt      <= '0;
            px_cnt     <= '0;
            shreg      <= '0;
            addr       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state == ACTIVE) begin
                armed <= 1'b0;
            end else if (hs_evt) begin
                armed <= 1'b1;
            end

            if (new_field_c) begin
                line_cnt <= '0;
                y_cnt    <= '0;
                addr     <= '0;
            end else begin
                if (vb_line_c) begin
                    line_cnt <= line_cnt + CNT_W'(1);
                end
                if (line_end_c && !last_line) begin
                    y_cnt <= y_cnt + CNT_W'(1);
                end
                if (write_c) begin
                    addr <= addr + ADDR_W'(1);
                end
            end

            if (sample_c) begin
                shreg  <= {shreg[6:0], pixel_s};
                px_cnt <= last_px ? '0 : px_cnt + PX_W'(1);
            end else if (state != ACTIVE) begin
                px_cnt <= '0;
            end

            wr_en <= write_c;
            if (write_c) begin
                wr_data <= {shreg[6:0], pixel_s};
                wr_addr <= addr;
            end

            frame_done <= (state == DONE);
            busy       <= (state_nx != IDLE);

            if (abort_c) begin
                err <= 1'b1;
            end else if ((state == IDLE) && !enable) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vbs_capture.sv
// tb_vbs_capture: directed bench for vbs_capture with a reduced frame size
// (32 x 4 pixels, 2 blank lines after field sync) to keep runs short.
module tb_vbs_capture;
    import vbs_pkg::*;

    localparam int unsigned XS       = 94;
    localparam int unsigned XP       = 32;
    localparam int unsigned YL       = 4;
    localparam int unsigned YS       = 3;
    localparam int unsigned BPL      = XP / 8;
    localparam int unsigned FB       = BPL * YL;
    localparam int unsigned LINE_LEN = XS + XP + 10;
    localparam int unsigned HS_LOW   = 29;
`ifdef VBS_CAPTURE_GLITCH_FILTER_EN
    localparam int GLITCH_HS = 0;
`else
    localparam int GLITCH_HS = 1;
`endif

    typedef struct {
        logic [XP-1:0]     px;
        logic [0:3][7:0]   b;
    } line_vec_t;

    typedef struct {
        int low;
        int exp_hs;
        int exp_vs;
    } pulse_vec_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              sync;
    logic              pixel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              busy;
    logic              err;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int vs_cnt = 0;
    int fd_cnt = 0;
    int wr_in_frame = 0;
    int exp_addr_q[$];
    int exp_data_q[$];

    line_vec_t  lines[8];
    pulse_vec_t pulses[6];

    always #5 clk = ~clk;

    vbs_capture #(
        .Y_START  (YS),
        .X_START  (XS),
        .X_PIXELS (XP),
        .Y_LINES  (YL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sync       (sync),
        .pixel      (pixel),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Scoreboard for RAM writes plus event counters.
    always @(negedge clk) begin
        if (dut.u_sep.hs_evt) hs_cnt++;
        if (dut.u_sep.vs_evt) vs_cnt++;
        if (wr_en) begin
            wr_in_frame++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, no write required",
                         wr_addr, wr_data);
            end else begin
                chk("wr_addr", int'(wr_addr), exp_addr_q.pop_front());
                chk("wr_data", int'(wr_data), exp_data_q.pop_front());
            end
        end
        if (frame_done) begin
            fd_cnt++;
            chk("bytes_before_frame_done", wr_in_frame, FB);
        end
    end

    task automatic tick(input logic s, input logic p);
        @(negedge clk);
        sync  = s;
        pixel = p;
    endtask

    task automatic gen_pulse(input int low, input int high);
        for (int c = 0; c < low; c++) tick(1'b0, 1'b0);
        for (int c = 0; c < high; c++) tick(1'b1, 1'b0);
    endtask

    task automatic gen_vs();
        wr_in_frame = 0;
        gen_pulse(210, 30);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // One video line; rst_at >= 0 pulses reset_n low for one clk at that offset.
    task automatic gen_line(input logic [XP-1:0] px, input int rst_at);
        logic p;
        for (int c = 0; c < int'(LINE_LEN); c++) begin
            p = 1'b0;
            if (c >= int'(XS) && c < int'(XS + XP)) p = px[int'(XP) - 1 - (c - int'(XS))];
            tick(c >= int'(HS_LOW), p);
            if (c == rst_at) begin
                reset_n = 1'b0;
                wr_in_frame = 0;
                #1;
                check_all_zero("reset_mid_active");
            end else begin
                reset_n = 1'b1;
            end
        end
    endtask

    task automatic push_line(input int idx, input int row);
        for (int k = 0; k < int'(BPL); k++) begin
            exp_addr_q.push_back(row * int'(BPL) + k);
            exp_data_q.push_back(int'(lines[idx].b[k]));
        end
    endtask

    // Blank lines, YL data lines from the table, then a short idle gap.
    task automatic frame_body(input int first, input bit drop_enable);
        for (int i = 0; i < int'(YS) - 1; i++) gen_line('0, -1);
        for (int i = 0; i < int'(YL); i++) begin
            if (drop_enable && i == int'(YL) - 1) enable = 1'b0;
            push_line(first + i, i);
            gen_line(lines[first + i].px, -1);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    endtask

    initial begin
        int h0;
        int v0;
        int f0;

        lines[0] = '{px: 32'h8000_0000, b: {8'h80, 8'h00, 8'h00, 8'h00}};
        lines[1] = '{px: 32'hAA55_F00F, b: {8'hAA, 8'h55, 8'hF0, 8'h0F}};
        lines[2] = '{px: 32'h0000_0001, b: {8'h00, 8'h00, 8'h00, 8'h01}};
        lines[3] = '{px: 32'hFFFF_FFFF, b: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        lines[4] = '{px: 32'h0123_4567, b: {8'h01, 8'h23, 8'h45, 8'h67}};
        lines[5] = '{px: 32'hC3C3_3C3C, b: {8'hC3, 8'hC3, 8'h3C, 8'h3C}};
        lines[6] = '{px: 32'h0000_0000, b: {8'h00, 8'h00, 8'h00, 8'h00}};
        lines[7] = '{px: 32'h8001_8001, b: {8'h80, 8'h01, 8'h80, 8'h01}};

        pulses[0] = '{low: 29,  exp_hs: 1,         exp_vs: 0};
        pulses[1] = '{low: 41,  exp_hs: 0,         exp_vs: 0};
        pulses[2] = '{low: 40,  exp_hs: 1,         exp_vs: 0};
        pulses[3] = '{low: 200, exp_hs: 0,         exp_vs: 1};
        pulses[4] = '{low: 199, exp_hs: 0,         exp_vs: 0};
        pulses[5] = '{low: 1,   exp_hs: GLITCH_HS, exp_vs: 0};

        reset_n = 1'b0;
        enable  = 1'b0;
        sync    = 1'b1;
        pixel   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);

        // Sync pulse classification while idle.
        for (int i = 0; i < 6; i++) begin
            h0 = hs_cnt;
            v0 = vs_cnt;
            gen_pulse(pulses[i].low, 30);
            chk($sformatf("hs_count_low%0d", pulses[i].low), hs_cnt - h0, pulses[i].exp_hs);
            chk($sformatf("vs_count_low%0d", pulses[i].low), vs_cnt - v0, pulses[i].exp_vs);
        end
        chk("busy_idle", int'(busy), 0);

        // Two back-to-back frames from the line table.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("busy_armed", int'(busy), 1);
        f0 = fd_cnt;
        gen_vs();
        frame_body(0, 1'b0);
        chk("frame_a_done", fd_cnt - f0, 1);
        chk("frame_a_pending", exp_addr_q.size(), 0);
        chk("busy_rearmed", int'(busy), 1);
        f0 = fd_cnt;
        gen_vs();
        frame_body(4, 1'b1);
        chk("frame_b_done", fd_cnt - f0, 1);
        chk("frame_b_pending", exp_addr_q.size(), 0);
        chk("busy_after_disable", int'(busy), 0);

        // Field sync arriving after the first captured line.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        gen_vs();
        for (int i = 0; i < int'(YS) - 1; i++) gen_line('0, -1);
        push_line(1, 0);
        gen_line(lines[1].px, -1);
        chk("err_before_abort", int'(err), 0);
        f0 = fd_cnt;
        gen_vs();
        chk("err_after_midframe_vs", int'(err), 1);
        chk("abort_pending", exp_addr_q.size(), 0);
        frame_body(4, 1'b1);
        chk("abort_frame_done", fd_cnt - f0, 1);
        chk("abort_pending_end", exp_addr_q.size(), 0);
        chk("err_cleared_idle", int'(err), 0);

        // Reset pulse in the middle of the second line's active region.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        gen_vs();
        for (int i = 0; i < int'(YS) - 1; i++) gen_line('0, -1);
        push_line(2, 0);
        gen_line(lines[2].px, -1);
        exp_addr_q.push_back(4);
        exp_data_q.push_back(8'h01);
        exp_addr_q.push_back(5);
        exp_data_q.push_back(8'h23);
        f0 = fd_cnt;
        gen_line(lines[4].px, int'(XS) + 23);
        chk("reset_pending", exp_addr_q.size(), 0);
        chk("reset_no_frame_done", fd_cnt - f0, 0);
        chk("busy_after_reset", int'(busy), 1);
        gen_vs();
        frame_body(0, 1'b1);
        chk("post_reset_frame_done", fd_cnt - f0, 1);
        chk("post_reset_pending", exp_addr_q.size(), 0);
        chk("post_reset_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
